tt_um_uwasic_onboarding_gregory_usharov: RTL and testbench

TinyTapeout user tile: an SPI-programmable 16-channel output controller.
- An SPI peripheral (write-only) loads five 8-bit control registers.
- Registers select, per output pin, static low, static high, or a shared PWM waveform (~3 kHz at a 10 MHz system clock).
- Outputs drive uo_out (channels 7:0) and uio_out (channels 15:8).

---
 rtl/tt_um_uwasic_onboarding_gregory_usharov_pkg.sv | 17 +
 rtl/tt_um_uwasic_onboarding_gregory_usharov_spi_peripheral.sv | 98 +++++++++
 rtl/tt_um_uwasic_onboarding_gregory_usharov.sv | 68 ++++++
 tb/tb_tt_um_uwasic_onboarding_gregory_usharov.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_uwasic_onboarding_gregory_usharov_pkg.sv
// Shared constants for the SPI-programmable 16-channel output controller:
// register map, SPI frame length and PWM prescaler settings.
package tt_um_uwasic_onboarding_gregory_usharov_pkg;

    localparam int CLK_DIV    = 13;
    localparam int NUM_REGS   = 5;
    localparam int FRAME_BITS = 16;
    localparam int PRESC_W    = $clog2(CLK_DIV);
    localparam int BIT_CNT_W  = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

endpackage

// File: rtl/tt_um_uwasic_onboarding_gregory_usharov_spi_peripheral.sv
// Write-only SPI mode-0 peripheral: synchronizes SCLK/COPI/nCS, shifts in
// 16-bit frames and commits valid writes into the five control registers.
module tt_um_uwasic_onboarding_gregory_usharov_spi_peripheral
    import tt_um_uwasic_onboarding_gregory_usharov_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sclk,
    input  logic        i_copi,
    input  logic        i_ncs,
    output logic [15:0] o_en_out,
    output logic [15:0] o_en_pwm,
    output logic [7:0]  o_duty
);

    localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_BITS);

    logic [1:0]           r_sclk_sync;
    logic [1:0]           r_copi_sync;
    logic [1:0]           r_ncs_sync;
    logic                 r_sclk_prev;
    logic                 r_ncs_prev;
    logic [15:0]          r_shift;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]           r_en_out_lo;
    logic [7:0]           r_en_out_hi;
    logic [7:0]           r_en_pwm_lo;
    logic [7:0]           r_en_pwm_hi;
    logic [7:0]           r_duty;

    logic w_sclk_rise;
    logic w_ncs_fall;
    logic w_ncs_rise;
    logic w_commit;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_prev;
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_prev;

    // Bit counter runs one past FRAME_LEN so over-long frames are recognisable.
    assign w_commit = w_ncs_rise
                    && (r_bit_cnt == FRAME_LEN)
                    && r_shift[15]
                    && (r_shift[14:8] <= ADDR_DUTY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_sclk};
            r_copi_sync <= {r_copi_sync[0], i_copi};
            r_ncs_sync  <= {r_ncs_sync[0], i_ncs};
            r_sclk_prev <= r_sclk_sync[1];
            r_ncs_prev  <= r_ncs_sync[1];
            if (w_ncs_fall) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_sclk_rise && !r_ncs_sync[1]) begin
                if (r_bit_cnt < FRAME_LEN) begin
                    r_shift <= {r_shift[14:0], r_copi_sync[1]};
                end
                if (r_bit_cnt <= FRAME_LEN) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_out_lo <= '0;
            r_en_out_hi <= '0;
            r_en_pwm_lo <= '0;
            r_en_pwm_hi <= '0;
            r_duty      <= '0;
        end else if (w_commit) begin
            case (r_shift[14:8])
                ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[7:0];
                ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[7:0];
                ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[7:0];
                ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[7:0];
                ADDR_DUTY:      r_duty      <= r_shift[7:0];
                default:        ;
            endcase
        end
    end

    assign o_en_out = {r_en_out_hi, r_en_out_lo};
    assign o_en_pwm = {r_en_pwm_hi, r_en_pwm_lo};
    assign o_duty   = r_duty;

endmodule

// File: rtl/tt_um_uwasic_onboarding_gregory_usharov.sv
// TinyTapeout tile top: SPI-loaded control registers drive 16 output channels,
// each statically low, statically high, or following a shared ~3 kHz PWM.
module tt_um_uwasic_onboarding_gregory_usharov
    import tt_um_uwasic_onboarding_gregory_usharov_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic [15:0]        w_en_out;
    logic [15:0]        w_en_pwm;
    logic [7:0]         w_duty;
    logic               w_pwm;
    logic [15:0]        w_chan;
    logic               w_unused;
    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_pwm_cnt;
    logic [15:0]        r_out;

    tt_um_uwasic_onboarding_gregory_usharov_spi_peripheral u_spi (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sclk   (ui_in[0]),
        .i_copi   (ui_in[1]),
        .i_ncs    (ui_in[2]),
        .o_en_out (w_en_out),
        .o_en_pwm (w_en_pwm),
        .o_duty   (w_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Full-scale duty is forced high so the 255 count does not produce a dip.
    assign w_pwm  = (w_duty == 8'hFF) || (r_pwm_cnt < w_duty);
    assign w_chan = w_en_out & (~w_en_pwm | {16{w_pwm}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_chan;
        end
    end

    assign uo_out   = r_out[7:0];
    assign uio_out  = r_out[15:8];
    assign uio_oe   = 8'hFF;
    assign w_unused = &{1'b0, ena, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_gregory_usharov.sv
// Directed self-checking bench for the SPI-programmable output controller.
module tb_tt_um_uwasic_onboarding_gregory_usharov;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       sclk;
    logic       copi;
    logic       ncs;

    int n_cmp;
    int n_bad;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    tt_um_uwasic_onboarding_gregory_usharov dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // 100 kHz SCLK: 50 system clocks per half period.
    task automatic spi_frame(input logic [15:0] word, input int nbits);
        logic [31:0] sh;
        ncs = 1'b0;
        wait_clks(50);
        for (int i = 0; i < nbits; i++) begin
            sh   = {word, 16'h0000} << i;
            copi = sh[31];
            wait_clks(50);
            sclk = 1'b1;
            wait_clks(50);
            sclk = 1'b0;
        end
        wait_clks(50);
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clks(20);
        @(negedge clk);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
        spi_frame({1'b1, addr, data}, 16);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clks(10);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(5);
        @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        n_cmp++;
        if (uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_uio_out: got %h expected 00", uio_out);
        end
        n_cmp++;
        if (uio_oe !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_uio_oe: got %h expected ff", uio_oe);
        end
    endtask

    task automatic test_static_high;
        spi_write(7'h00, 8'hF0);
        n_cmp++;
        if (uo_out !== 8'hF0) begin
            n_bad++;
            $display("FAIL static_lo: got %h expected f0", uo_out);
        end
        spi_write(7'h01, 8'hCC);
        n_cmp++;
        if (uo_out !== 8'hF0 || uio_out !== 8'hCC) begin
            n_bad++;
            $display("FAIL static_hi: got %h/%h expected f0/cc", uo_out, uio_out);
        end
    endtask

    task automatic test_rejects;
        logic [15:0] frames [5];
        int          lens   [5];
        frames[0] = 16'hB0AA; lens[0] = 16;  // address 0x30
        frames[1] = 16'h0000; lens[1] = 16;  // read of 0x00
        frames[2] = 16'h8100; lens[2] = 12;  // truncated write
        frames[3] = 16'h8000; lens[3] = 17;  // over-long write
        frames[4] = 16'h8500; lens[4] = 16;  // first address past the map
        for (int k = 0; k < 5; k++) begin
            spi_frame(frames[k], lens[k]);
            n_cmp++;
            if (uo_out !== 8'hF0 || uio_out !== 8'hCC) begin
                n_bad++;
                $display("FAIL reject_%0d: got %h/%h expected f0/cc", k, uo_out, uio_out);
            end
        end
    endtask

    task automatic test_pwm50;
        int  cyc;
        int  high_t;
        int  low_t;
        bit  tmo;
        spi_write(7'h00, 8'h01);
        spi_write(7'h02, 8'h01);
        spi_write(7'h04, 8'h80);
        tmo = 1'b0;
        cyc = 0;
        while (uo_out[0] !== 1'b0 && cyc < 8000) begin @(negedge clk); cyc++; end
        if (cyc >= 8000) tmo = 1'b1;
        cyc = 0;
        while (uo_out[0] !== 1'b1 && cyc < 8000) begin @(negedge clk); cyc++; end
        if (cyc >= 8000) tmo = 1'b1;
        high_t = 0;
        while (uo_out[0] === 1'b1 && high_t < 8000) begin @(negedge clk); high_t++; end
        low_t = 0;
        while (uo_out[0] !== 1'b1 && low_t < 8000) begin @(negedge clk); low_t++; end
        n_cmp++;
        if (tmo) begin
            n_bad++;
            $display("FAIL pwm50_edge: got timeout expected pwm edges");
        end
        n_cmp++;
        if (high_t != 1664) begin
            n_bad++;
            $display("FAIL pwm50_high: got %0d expected 1664", high_t);
        end
        n_cmp++;
        if (high_t + low_t != 3328) begin
            n_bad++;
            $display("FAIL pwm50_period: got %0d expected 3328", high_t + low_t);
        end
    endtask

    task automatic test_duty_extremes;
        int highs;
        int lows;
        spi_write(7'h04, 8'h00);
        highs = 0;
        for (int i = 0; i < 2 * 3328; i++) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b0) highs++;
        end
        n_cmp++;
        if (highs != 0) begin
            n_bad++;
            $display("FAIL duty00: got %0d high cycles expected 0", highs);
        end
        spi_write(7'h04, 8'hFF);
        lows = 0;
        for (int i = 0; i < 2 * 3328; i++) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++;
            $display("FAIL dutyFF: got %0d low cycles expected 0", lows);
        end
    endtask

    task automatic test_enable_gating;
        int other;
        int h7;
        int l7;
        spi_write(7'h00, 8'h00);
        spi_write(7'h01, 8'h00);
        spi_write(7'h02, 8'hFF);
        spi_write(7'h03, 8'hFF);
        spi_write(7'h04, 8'h80);
        other = 0;
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk);
            if (uo_out !== 8'h00 || uio_out !== 8'h00) other++;
        end
        n_cmp++;
        if (other != 0) begin
            n_bad++;
            $display("FAIL gate_all_off: got %0d active cycles expected 0", other);
        end
        spi_write(7'h01, 8'h80);
        other = 0;
        h7 = 0;
        l7 = 0;
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk);
            if (uo_out !== 8'h00 || uio_out[6:0] !== 7'h00) other++;
            if (uio_out[7] === 1'b1) h7++;
            else l7++;
        end
        n_cmp++;
        if (other != 0) begin
            n_bad++;
            $display("FAIL gate_others: got %0d active cycles expected 0", other);
        end
        n_cmp++;
        if (h7 == 0 || l7 == 0) begin
            n_bad++;
            $display("FAIL gate_ch15: got high=%0d low=%0d expected both nonzero", h7, l7);
        end
    endtask

    task automatic test_reset_mid_frame;
        ncs = 1'b0;
        wait_clks(50);
        for (int i = 0; i < 5; i++) begin
            copi = 1'b1;
            wait_clks(50);
            sclk = 1'b1;
            wait_clks(50);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        wait_clks(10);
        @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_clear: got %h/%h expected 00/00", uo_out, uio_out);
        end
        rst_n = 1'b1;
        ncs   = 1'b1;
        copi  = 1'b0;
        wait_clks(20);
        spi_write(7'h00, 8'h5A);
        n_cmp++;
        if (uo_out !== 8'h5A || uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_next: got %h/%h expected 5a/00", uo_out, uio_out);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        ena    = 1'b1;
        uio_in = 8'h00;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        rst_n  = 1'b1;
        test_reset();
        test_static_high();
        test_rejects();
        test_pwm50();
        test_duty_extremes();
        test_enable_gating();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
